// File: rtl/bus_arbiter4_4bit_pkg.sv
// Shared constants for the 4-requester bus arbiter and the issue logic that feeds it.
package bus_arbiter4_4bit_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic OWNED = 1'b1;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = IDLE,
        ST_OWNED = OWNED
    } arb_state_t;

endpackage

// File: rtl/mux4_1_4bit.sv
// 4:1 multiplexer, 4 bits wide; select picks which input reaches the output.
module mux4_1_4bit (
    input  logic [1:0] sel,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    output logic [3:0] out
);

    // Data path selection
    always_comb begin
        out = 4'b0000;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            2'd3:    out = in3;
            default: out = 4'b0000;
        endcase
    end

endmodule

// File: rtl/bus_arbiter4_4bit.sv
// Round-robin arbiter owning the select of a shared 4:1 4-bit bus mux,
// with a per-tenure hold limit that forces rotation under contention.
module bus_arbiter4_4bit
    import bus_arbiter4_4bit_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [3:0]       in0,
    input  logic [3:0]       in1,
    input  logic [3:0]       in2,
    input  logic [3:0]       in3,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic [3:0]       out
);

    localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT_C  = {HOLD_W{1'b1}};
    localparam bit                UNLIMITED_C = (MAX_HOLD == 0);

    arb_state_t        state_r;
    logic [SEL_W-1:0]  ptr_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [NREQ-1:0]   gnt_r;
    logic [SEL_W-1:0]  sel_r;
    logic              valid_r;

    logic [SEL_W:0]    win_s;
    logic              keep_s;
    logic [HOLD_W-1:0] hold_inc_s;
    logic [3:0]        mux_out_s;
    logic [3:0]        out_s;

    // Returns {found, index}; search starts at start and wraps, lowest offset wins.
    function automatic logic [SEL_W:0] pick_winner(input logic [NREQ-1:0] req_v,
                                                   input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   result;
        logic [SEL_W-1:0] idx;
        result = {1'b0, {SEL_W{1'b0}}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (req_v[idx]) begin
                result = {1'b1, idx};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Next winner, tenure continuation and saturating tenure increment
    always_comb begin
        win_s      = pick_winner(req, ptr_r);
        keep_s     = 1'b0;
        hold_inc_s = hold_cnt_r;
        if (req[sel_r]) begin
            if (UNLIMITED_C) begin
                keep_s = 1'b1;
            end else if (hold_cnt_r < HOLD_LAST_C) begin
                keep_s = 1'b1;
            end else begin
                keep_s = 1'b0;
            end
        end else begin
            keep_s = 1'b0;
        end
        if (hold_cnt_r != HOLD_SAT_C) begin
            hold_inc_s = hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_inc_s = hold_cnt_r;
        end
    end

    // Arbitration state machine with registered grant, select and valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {SEL_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            gnt_r      <= {NREQ{1'b0}};
            sel_r      <= {SEL_W{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_s[SEL_W]) begin
                        state_r    <= ST_OWNED;
                        gnt_r      <= NREQ'(1) << win_s[SEL_W-1:0];
                        sel_r      <= win_s[SEL_W-1:0];
                        valid_r    <= 1'b1;
                        ptr_r      <= win_s[SEL_W-1:0] + SEL_W'(1);
                        hold_cnt_r <= {HOLD_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OWNED: begin
                    if (keep_s) begin
                        hold_cnt_r <= hold_inc_s;
                    end else if (win_s[SEL_W]) begin
                        // ptr already points past the owner, so it loses ties
                        gnt_r      <= NREQ'(1) << win_s[SEL_W-1:0];
                        sel_r      <= win_s[SEL_W-1:0];
                        valid_r    <= 1'b1;
                        ptr_r      <= win_s[SEL_W-1:0] + SEL_W'(1);
                        hold_cnt_r <= {HOLD_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                        gnt_r   <= {NREQ{1'b0}};
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    gnt_r      <= {NREQ{1'b0}};
                    valid_r    <= 1'b0;
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    mux4_1_4bit u_mux (
        .sel (sel_r),
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .out (mux_out_s)
    );

    // Bus data is forced to zero while nobody owns the bus
    always_comb begin
        out_s = 4'b0000;
        if (valid_r) begin
            out_s = mux_out_s;
        end else begin
            out_s = 4'b0000;
        end
    end

    assign gnt   = gnt_r;
    assign sel   = sel_r;
    assign valid = valid_r;
    assign out   = out_s;

endmodule
